fpdiv_ctrl: RTL and testbench
=============================

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter: NITER, 3, number of Goldschmidt refinement iterations; legal 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller idle and able to accept operands.
REQ-006 inputNum  input  32  IEEE single numerator.
REQ-007 inputDenom  input  32  IEEE single denominator.
REQ-008 rm_in  input  1  rounding mode (1 = RN, 0 = RZ).
REQ-009 abort  input  1  synchronous cancel of an operation in flight.
REQ-010 num_q  output  32  registered numerator, stable for the whole operation.
REQ-011 denom_q  output  32  registered denominator.
REQ-012 rm_q  output  1  registered rounding mode.
REQ-013 en_a, en_b, en_rem  output  1 each  datapath register enables.
REQ-014 sel_mux3  output  2  0 = initial approximation, 1 = regc, 2 = denominator.
REQ-015 sel_mux4  output  2  0 = numerator, 1 = denominator, 2 = rega, 3 = regb.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 out_valid  output  1  datapath result (final_ans) valid.
REQ-018 out_ready  input  1  consumer accepts the result.

Function
REQ-019 States: IDLE, LOADA, LOADB, ITERA, ITERB, REM, DONE.
REQ-020 IDLE: in_ready = 1; on in_valid, capture inputNum, inputDenom and rm_in and go to LOADA.
REQ-021 LOADA: sel_mux3 = 0, sel_mux4 = 0, en_a = 1; go to LOADB.
REQ-022 LOADB: sel_mux3 = 0, sel_mux4 = 1, en_b = 1; clear the iteration counter; go to ITERA.
REQ-023 ITERA: sel_mux3 = 1, sel_mux4 = 2, en_a = 1; go to ITERB.
REQ-024 ITERB: sel_mux3 = 1, sel_mux4 = 3, en_b = 1; increment the counter; go to REM if the counter was NITER-1, else to ITERA.
REQ-025 REM: sel_mux3 = 2, sel_mux4 = 2, en_rem = 1; go to DONE.
REQ-026 DONE: out_valid = 1, all enables 0; hold until out_ready, then go to IDLE.
REQ-027 A new operand pair is never accepted in DONE; in_ready rises the cycle after the out_valid/out_ready handshake.
REQ-028 Latency: out_valid asserts exactly 4 + 2*NITER cycles after the accepting clock edge (10 for NITER = 3).
REQ-029 At most one enable is high in any cycle.
REQ-030 All control outputs are decoded from the registered state and counter only (Moore); none depend combinationally on the handshake inputs.
REQ-031 In IDLE and DONE, sel_mux3 and sel_mux4 are 0.
REQ-032 num_q, denom_q and rm_q change only on an accepted in_valid in IDLE.
REQ-033 abort in any non-IDLE state returns the FSM to IDLE at the next edge, with no out_valid for that operation; the operand registers are kept.
REQ-034 abort in IDLE is ignored; abort and in_valid together in IDLE accept the operands.
REQ-035 abort in DONE discards the result even when out_ready is also high.

Reset
REQ-036 Reset low forces state IDLE, counter 0, num_q/denom_q 0, rm_q 0, all enables 0, selects 0, busy 0 and out_valid 0; in_ready = 1 when reset is released.
REQ-037 Reset asserted mid-operation cancels the operation immediately, with no out_valid.

Structure
REQ-038 fpdiv_pkg holds the state enum, the sel_mux3/sel_mux4 encoding constants and the NITER default.
REQ-039 Operand capture uses the existing flopenr with reset adapted to the active-low input; no other sub-module is used.

Verification
REQ-040 NITER = 3; 6.0 / 1.5 accepted at edge 0 -> enable sequence a,b,a,b,a,b,a,b,rem; out_valid at cycle 10; the datapath yields 0x40800000.
REQ-041 out_ready held low 5 cycles in DONE -> out_valid held, in_ready 0, then IDLE one cycle after out_ready.
REQ-042 abort asserted during the second ITERA -> IDLE next edge, no out_valid, in_ready 1.
REQ-043 Reset pulsed low during ITERB -> all outputs 0 asynchronously; a new divide afterwards completes normally.
REQ-044 NITER = 1 build -> out_valid 6 cycles after accept; NITER = 7 -> 18 cycles.
REQ-045 in_valid held high across back-to-back operations -> second accept one cycle after the first result handshake; the operand registers stay unchanged during the first operation.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared state encoding and mux select constants for the
// Goldschmidt divider controller
package fpdiv_pkg;

  localparam int NITER_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_ITERA = 3'd3,
    S_ITERB = 3'd4,
    S_REM   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] MUX3_APPROX = 2'd0;
  localparam logic [1:0] MUX3_REGC   = 2'd1;
  localparam logic [1:0] MUX3_DENOM  = 2'd2;

  localparam logic [1:0] MUX4_NUM    = 2'd0;
  localparam logic [1:0] MUX4_DENOM  = 2'd1;
  localparam logic [1:0] MUX4_REGA   = 2'd2;
  localparam logic [1:0] MUX4_REGB   = 2'd3;

endpackage

// File: rtl/fpdiv_ctrl_flopenr.sv
// rtl/fpdiv_ctrl_flopenr.sv - enabled register with asynchronous active-low
// clear, used for operand capture
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - Moore controller sequencing load, NITER Goldschmidt
// refinements and the remainder step of a single-precision divider
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int NITER = NITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inputNum,
  input  logic [31:0] inputDenom,
  input  logic        rm_in,
  input  logic        abort,
  output logic [31:0] num_q,
  output logic [31:0] denom_q,
  output logic        rm_q,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic [1:0]  sel_mux3,
  output logic [1:0]  sel_mux4,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t     state;
  state_t     state_n;
  logic [2:0] iter_cnt;
  logic       capture;

  // Operands are only loaded on an accepted request so the datapath sees
  // stable inputs for the whole operation, even after an abort.
  assign capture = (state == S_IDLE) && in_valid;

  flopenr #(.WIDTH(65)) u_operands (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     ({rm_in, inputDenom, inputNum}),
    .q     ({rm_q, denom_q, num_q})
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= 3'd0;
    end else begin
      state <= state_n;
      if (state == S_LOADB) begin
        iter_cnt <= 3'd0;
      end else if (state == S_ITERB) begin
        iter_cnt <= iter_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_rem    = 1'b0;
    sel_mux3  = MUX3_APPROX;
    sel_mux4  = MUX4_NUM;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_n = S_LOADA;
      end
      S_LOADA: begin
        en_a    = 1'b1;
        state_n = S_LOADB;
      end
      S_LOADB: begin
        sel_mux4 = MUX4_DENOM;
        en_b     = 1'b1;
        state_n  = S_ITERA;
      end
      S_ITERA: begin
        sel_mux3 = MUX3_REGC;
        sel_mux4 = MUX4_REGA;
        en_a     = 1'b1;
        state_n  = S_ITERB;
      end
      S_ITERB: begin
        sel_mux3 = MUX3_REGC;
        sel_mux4 = MUX4_REGB;
        en_b     = 1'b1;
        state_n  = (iter_cnt == 3'(NITER - 1)) ? S_REM : S_ITERA;
      end
      S_REM: begin
        sel_mux3 = MUX3_DENOM;
        sel_mux4 = MUX4_REGA;
        en_rem   = 1'b1;
        state_n  = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Cancel wins over everything outside IDLE, including a DONE handshake.
    if (abort && (state != S_IDLE)) state_n = S_IDLE;
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb/tb_fpdiv_ctrl.sv - self-checking bench for fpdiv_ctrl
module tb_fpdiv_ctrl;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inputNum = '0;
  logic [31:0] inputDenom = '0;
  logic        rm_in = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, rm_q, en_a, en_b, en_rem, busy, out_valid;
  logic [31:0] num_q, denom_q;
  logic [1:0]  sel_mux3, sel_mux4;

  logic        r1, q1, a1, b1, m1, y1, v1;
  logic [31:0] n1, d1;
  logic [1:0]  s31, s41;
  logic        r7, q7, a7, b7, m7, y7, v7;
  logic [31:0] n7, d7;
  logic [1:0]  s37, s47;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.NITER(N)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inputNum(inputNum), .inputDenom(inputDenom), .rm_in(rm_in), .abort(abort),
    .num_q(num_q), .denom_q(denom_q), .rm_q(rm_q), .en_a(en_a), .en_b(en_b),
    .en_rem(en_rem), .sel_mux3(sel_mux3), .sel_mux4(sel_mux4), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fpdiv_ctrl #(.NITER(1)) u_n1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1),
    .inputNum(inputNum), .inputDenom(inputDenom), .rm_in(rm_in), .abort(abort),
    .num_q(n1), .denom_q(d1), .rm_q(q1), .en_a(a1), .en_b(b1),
    .en_rem(m1), .sel_mux3(s31), .sel_mux4(s41), .busy(y1),
    .out_valid(v1), .out_ready(out_ready)
  );

  fpdiv_ctrl #(.NITER(7)) u_n7 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r7),
    .inputNum(inputNum), .inputDenom(inputDenom), .rm_in(rm_in), .abort(abort),
    .num_q(n7), .denom_q(d7), .rm_q(q7), .en_a(a7), .en_b(b7),
    .en_rem(m7), .sel_mux3(s37), .sel_mux4(s47), .busy(y7),
    .out_valid(v7), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: an operation is a count of edges since acceptance; the schedule
  // (load a, load b, N refinement pairs, remainder, done) is read off that count.
  bit          m_busy;
  int          m_phase;
  logic [31:0] m_num, m_den;
  logic        m_rm;
  bit          cmp_on = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_phase = 0; m_num = '0; m_den = '0; m_rm = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_phase = 1; m_num = inputNum; m_den = inputDenom; m_rm = rm_in;
      end
    end else if (abort) begin
      m_busy = 0;
    end else if (m_phase == 4 + 2 * N) begin
      if (out_ready) m_busy = 0;
    end else begin
      m_phase++;
    end
  end

  bit       x_iter, x_a, x_b, x_rem, x_ov;
  bit [1:0] x_s3, x_s4;

  always @(negedge clk) begin
    if (reset && cmp_on) begin
      x_iter = m_busy && m_phase >= 3 && m_phase <= 2 + 2 * N;
      x_a    = m_busy && (m_phase == 1 || (x_iter && m_phase % 2 == 1));
      x_b    = m_busy && (m_phase == 2 || (x_iter && m_phase % 2 == 0));
      x_rem  = m_busy && m_phase == 3 + 2 * N;
      x_ov   = m_busy && m_phase == 4 + 2 * N;
      x_s3   = x_iter ? 2'd1 : (x_rem ? 2'd2 : 2'd0);
      x_s4   = (m_busy && m_phase == 2) ? 2'd1 :
               x_iter ? ((m_phase % 2 == 1) ? 2'd2 : 2'd3) :
               x_rem ? 2'd2 : 2'd0;
      chk("ctrl{a,b,rem,s3,s4,ov,busy,rdy}",
          {en_a, en_b, en_rem, sel_mux3, sel_mux4, out_valid, busy, in_ready},
          {x_a, x_b, x_rem, x_s3, x_s4, x_ov, m_busy, !m_busy});
      chk("operands{rm,den,num}", {rm_q, denom_q, num_q}, {m_rm, m_den, m_num});
    end
  end

  task automatic start_op(input logic [31:0] n, input logic [31:0] d, input logic r);
    @(negedge clk);
    inputNum = n; inputDenom = d; rm_in = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("wait_out_valid_timeout", 64'd0, 64'd1);
  endtask

  int    l1, l3, l7, lat;
  string seq;

  initial begin
    // reset state
    #12;
    chk("reset_outputs", {en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, out_valid, rm_q},
        9'd0);
    chk("reset_operands", {num_q, denom_q}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cmp_on = 1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // latency for NITER = 1, 3, 7
    out_ready = 1'b1;
    start_op(32'h3F800000, 32'h40000000, 1'b0);
    l1 = 0; l3 = 0; l7 = 0;
    for (int k = 1; k <= 30; k++) begin
      if (v1 && l1 == 0) l1 = k;
      if (out_valid && l3 == 0) l3 = k;
      if (v7 && l7 == 0) l7 = k;
      @(negedge clk);
    end
    chk("latency_n1", l1, 6);
    chk("latency_n3", l3, 10);
    chk("latency_n7", l7, 18);
    chk("n1_idle", {r1, y1, v1, a1, b1, m1, s31, s41}, 10'b10_0000_0000);
    chk("n7_idle", {r7, y7, v7, a7, b7, m7, s37, s47}, 10'b10_0000_0000);
    chk("n1_operands", {q1, d1, n1}, {1'b0, 32'h40000000, 32'h3F800000});
    chk("n7_operands", {q7, d7, n7}, {1'b0, 32'h40000000, 32'h3F800000});
    out_ready = 1'b0;

    // 6.0 / 1.5: enable order, latency, DONE hold for 5 cycles
    start_op(32'h40C00000, 32'h3FC00000, 1'b1);
    seq = "";
    for (int k = 1; k <= 9; k++) begin
      if (en_a) seq = {seq, "a"};
      if (en_b) seq = {seq, "b"};
      if (en_rem) seq = {seq, "r"};
      @(negedge clk);
    end
    tests++;
    if (seq != "ababababr") begin
      fails++;
      $display("FAIL enable_sequence: got %s, expected ababababr", seq);
    end
    chk("out_valid_at_10", out_valid, 1);
    chk("operands_6_over_1_5", {rm_q, num_q, denom_q}, {1'b1, 32'h40C00000, 32'h3FC00000});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("done_hold", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_handshake", {in_ready, out_valid, busy}, 3'b100);
    out_ready = 1'b0;

    // abort during the second ITERA
    start_op(32'h41200000, 32'h40A00000, 1'b0);
    repeat (4) @(negedge clk);
    chk("second_itera", {en_a, sel_mux3, sel_mux4}, 5'b1_01_10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_to_idle", {in_ready, busy, out_valid}, 3'b100);
    chk("abort_keeps_num", num_q, 32'h41200000);

    // async reset during ITERB, then a normal divide
    start_op(32'h40400000, 32'h3F800000, 1'b1);
    repeat (3) @(negedge clk);
    chk("in_iterb", {en_b, sel_mux4}, 3'b1_11);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_ctrl", {en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, out_valid, rm_q},
        9'd0);
    chk("async_reset_operands", {num_q, denom_q}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_midop_reset", in_ready, 1);
    start_op(32'h41000000, 32'h40000000, 1'b0);
    wait_valid(lat);
    chk("post_reset_latency", lat, 10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // back-to-back with in_valid held high
    @(negedge clk);
    inputNum = 32'h3F000000; inputDenom = 32'h3E800000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    inputNum = 32'h42000000; inputDenom = 32'h41000000;
    chk("b2b_first_capture", num_q, 32'h3F000000);
    wait_valid(lat);
    @(negedge clk);
    chk("b2b_gap_idle", {in_ready, num_q}, {1'b1, 32'h3F000000});
    @(negedge clk);
    chk("b2b_second_accept", {busy, num_q, denom_q}, {1'b1, 32'h42000000, 32'h41000000});
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_second_latency", lat, 10);
    @(negedge clk);
    out_ready = 1'b0;

    // abort in DONE with out_ready high discards the result
    start_op(32'h40000000, 32'h3F800000, 1'b1);
    wait_valid(lat);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_in_done", {in_ready, out_valid}, 2'b10);

    // abort together with in_valid in IDLE still accepts
    inputNum = 32'h40E00000; inputDenom = 32'h40000000; rm_in = 1'b1;
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_accepts", {busy, rm_q, num_q}, {1'b1, 1'b1, 32'h40E00000});
    out_ready = 1'b1;
    wait_valid(lat);
    chk("abort_idle_latency", lat, 10);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
